uart_tx_core: RTL and testbench
===============================

# uart_tx_core

Parametrised UART transmit engine with built-in transmit FIFO, bit-period timer and frame sequencer. It accepts words on a valid/ready write port and serialises them LSB-first with start bit, configurable data length, optional parity and one or two stop bits. It also supports a line-break request. It sits between the CSR/bus layer and the `tx` pad, and replaces the separate transmit datapath/controller pair in the UART.

## Interface
- `DATA_W`, 8: maximum data bits per frame (5..16).
- `FIFO_DEPTH`, 8: transmit FIFO entries; power of two, at least 2.
- `BAUD_W`, 32: width of the bit-period divisor.

- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_baud_div`  in  BAUD_W  clocks per bit; 0 is treated as 1.
- `cfg_data_bits`  in  5  data bits per frame; values outside 5..DATA_W are treated as DATA_W.
- `cfg_parity_en`  in  1  append a parity bit.
- `cfg_parity_odd`  in  1  1 = odd parity, 0 = even parity.
- `cfg_stop2`  in  1  1 = two stop bits, 0 = one stop bit.
- `cfg_break`  in  1  hold the line low while idle.
- `tx_enable`  in  1  permits new frames to start.
- `wr_valid`  in  1  write request.
- `wr_data`  in  DATA_W  word to send; bits at and above cfg_data_bits are ignored.
- `wr_ready`  out  1  FIFO can accept a word.
- `tx`  out  1  serial line output, registered.
- `busy`  out  1  frame in progress (state is not IDLE).
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- `fifo_empty`, `fifo_full`  out  1 each  FIFO status flags.

## Operation
- A write is accepted when `wr_valid && wr_ready`. `wr_ready = !fifo_full`, derived from the registered level only. There is no bypass: a write presented while the FIFO is full is refused, even if a pop occurs in the same cycle.
- FSM states and transitions:
  - IDLE -> START when `tx_enable && !fifo_empty && !cfg_break`.
  - START -> DATA.
  - DATA -> PARITY after N bits if parity is enabled, otherwise DATA -> STOP.
  - PARITY -> STOP.
  - STOP -> START or IDLE after S stop bits.
- On every START entry the core pops one FIFO word into the shift register. It latches N (effective data bits), the parity enable, the parity mode, S (1 or 2) and the divisor. Configuration changes mid-frame do not affect the current frame.
- `tx` value per state:
  - IDLE: 1, or 0 while `cfg_break`.
  - START: 0.
  - DATA: shift register bit 0; the register shifts right once per bit.
  - PARITY: XOR of the N data bits, inverted when odd parity is selected.
  - STOP: 1.
- The bit timer counts from 0 to div-1. A bit ends on the cycle the count reaches div-1, so every bit lasts exactly div cycles.
- Frame length is (1+N+P+S)·div cycles, where P is 1 with parity and 0 without.
- Back-to-back frames: at the end of the last stop bit, if the start condition holds, the core pops the next word and START begins on the next cycle. There is no idle gap between frames.
- Deasserting `tx_enable` mid-frame: the current frame completes, then the core stays in IDLE.
- `cfg_break` during a frame has no effect until IDLE. In IDLE with `cfg_break` set, no pops occur.
- Simultaneous push and pop when not full: `fifo_level` is unchanged and the pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: `tx`=1, `busy`=0, `wr_ready`=1, `fifo_level`=0, `fifo_empty`=1, `fifo_full`=0. The FSM resets to IDLE and the pointers and timer reset to 0.
- Reset asserted mid-frame aborts the frame immediately (`tx`=1 asynchronously) and discards the FIFO contents.
- Latency with an empty FIFO, idle core and `tx_enable`=1:
  - write accepted at cycle 0;
  - `fifo_empty` falls at cycle 1, and the pop and START entry occur at cycle 1;
  - `tx`=0 is first seen at cycle 2.
- `busy` rises in the same cycle `tx` first goes low. It falls in the cycle after the last stop bit ends, unless the next frame starts back-to-back.
- Status flags are registered and update the cycle after the push or pop.

## Test plan
- 8N1, div=4, write 0x55 -> `tx` gives 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles (40 cycles total). `busy` is high exactly for those 40 cycles.
- 7 data bits, odd parity, 2 stop bits, div=2, write 0x83:
  - data bits are 1,1,0,0,0,0,0 (bit 7 ignored);
  - parity bit is 1;
  - frame is 11 bits, 22 cycles.
  - With even parity the parity bit is 0.
- `tx_enable`=0, 9 consecutive writes -> 8 accepted; `fifo_full`=1, `wr_ready`=0 on the 9th, `fifo_level`=8. Then set `tx_enable`=1 -> 8 frames sent with no idle gaps and the level drains to 0.
- `cfg_data_bits`=3, div=0 -> frame behaves as 8 data bits at 1 cycle per bit (10-cycle 8N1 frame).
- Set `cfg_break` mid-frame -> the frame completes normally, then `tx` is held 0 with no pop while the FIFO is non-empty. Release `cfg_break` -> the next frame starts.
- Assert `rst_n`=0 during the DATA state with 3 words queued -> `tx`=1 immediately; after release `fifo_level`=0 and no frame starts.

Source files
------------

// File: rtl/uart_tx_core.sv
// uart_tx_core: UART transmit engine with built-in transmit FIFO, bit-period
// timer and frame sequencer. Words are serialised LSB-first with a start bit,
// N data bits, optional parity and one or two stop bits.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_baud_div               clocks per bit (0 behaves as 1)
//   cfg_data_bits              data bits per frame (outside 5..DATA_W -> DATA_W)
//   cfg_parity_en/_odd         parity enable / odd select
//   cfg_stop2                  two stop bits when set
//   cfg_break                  hold line low while idle
//   tx_enable                  permits new frames to start
//   wr_valid/wr_data/wr_ready  FIFO write port
//   tx                         registered serial output
//   busy                       frame in progress
//   fifo_level/_empty/_full    FIFO status
//
// state  | meaning
// -------+------------------------------------------------
// IDLE   | line idle (1, or 0 while break requested)
// START  | start bit (0)
// DATA   | data bits, LSB first from shift register
// PARITY | parity bit
// STOP   | one or two stop bits (1)
module uart_tx_core #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int BAUD_W     = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [BAUD_W-1:0]             cfg_baud_div,
  input  logic [4:0]                    cfg_data_bits,
  input  logic                          cfg_parity_en,
  input  logic                          cfg_parity_odd,
  input  logic                          cfg_stop2,
  input  logic                          cfg_break,
  input  logic                          tx_enable,
  input  logic                          wr_valid,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          fifo_empty,
  output logic                          fifo_full
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;
  logic              push, pop;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [4:0]        n_q, data_idx;
  logic              par_en_q, par_bit_q, stop2_q, stop_idx;
  logic [BAUD_W-1:0] div_q, bit_cnt;

  logic [4:0]        eff_n;
  logic [DATA_W-1:0] mask, rd_word;
  logic [BAUD_W-1:0] div_eff;
  logic              bit_end, last_data, last_stop, start_ok;

  // Flags come straight from the registered level, so a full FIFO refuses a
  // write even if a pop happens in the same cycle.
  assign fifo_level = level;
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LW'(FIFO_DEPTH));
  assign wr_ready   = !fifo_full;
  assign push       = wr_valid && wr_ready;
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_comb begin
    eff_n = cfg_data_bits;
    if (cfg_data_bits < 5'd5 || cfg_data_bits > 5'(DATA_W)) eff_n = 5'(DATA_W);
    mask = '0;
    for (int i = 0; i < DATA_W; i++) mask[i] = (i < int'(eff_n));
  end

  assign rd_word   = mem[rd_ptr] & mask;
  assign div_eff   = (cfg_baud_div == '0) ? BAUD_W'(1) : cfg_baud_div;
  assign bit_end   = (bit_cnt == div_q - BAUD_W'(1));
  assign last_data = (data_idx == n_q - 5'd1);
  assign last_stop = (stop_idx == stop2_q);
  assign start_ok  = tx_enable && !fifo_empty && !cfg_break;

  // A pop is also the START entry, both from IDLE and back-to-back at the end
  // of the final stop bit.
  assign pop = start_ok &&
               ((state == ST_IDLE) || (state == ST_STOP && bit_end && last_stop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tx        <= 1'b1;
      shreg     <= '0;
      n_q       <= 5'(DATA_W);
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      stop_idx  <= 1'b0;
      data_idx  <= '0;
      div_q     <= BAUD_W'(1);
      bit_cnt   <= '0;
    end else if (pop) begin
      // Frame configuration is captured here and held for the whole frame.
      state     <= ST_START;
      tx        <= 1'b0;
      shreg     <= rd_word;
      n_q       <= eff_n;
      par_en_q  <= cfg_parity_en;
      par_bit_q <= (^rd_word) ^ cfg_parity_odd;
      stop2_q   <= cfg_stop2;
      stop_idx  <= 1'b0;
      data_idx  <= '0;
      div_q     <= div_eff;
      bit_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          tx <= !cfg_break;
        end
        ST_START: begin
          if (bit_end) begin
            state    <= ST_DATA;
            tx       <= shreg[0];
            data_idx <= '0;
            bit_cnt  <= '0;
          end else begin
            bit_cnt <= bit_cnt + BAUD_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (last_data) begin
              if (par_en_q) begin
                state <= ST_PARITY;
                tx    <= par_bit_q;
              end else begin
                state    <= ST_STOP;
                tx       <= 1'b1;
                stop_idx <= 1'b0;
              end
            end else begin
              shreg    <= shreg >> 1;
              tx       <= shreg[1];
              data_idx <= data_idx + 5'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + BAUD_W'(1);
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            state    <= ST_STOP;
            tx       <= 1'b1;
            stop_idx <= 1'b0;
            bit_cnt  <= '0;
          end else begin
            bit_cnt <= bit_cnt + BAUD_W'(1);
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (last_stop) begin
              state <= ST_IDLE;
              tx    <= !cfg_break;
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + BAUD_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
module tb_uart_tx_core;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int BAUD_W     = 32;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [BAUD_W-1:0] cfg_baud_div;
  logic [4:0]        cfg_data_bits;
  logic              cfg_parity_en, cfg_parity_odd, cfg_stop2, cfg_break;
  logic              tx_enable, wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready, tx, busy, fifo_empty, fifo_full;
  logic [LW-1:0]     fifo_level;

  typedef struct {
    logic [15:0] value;
    int          n;
    bit          par_en;
    bit          odd;
    bit          stop2;
    int          div;
  } frame_t;

  frame_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  uart_tx_core #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .BAUD_W(BAUD_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_baud_div(cfg_baud_div), .cfg_data_bits(cfg_data_bits),
    .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd), .cfg_stop2(cfg_stop2),
    .cfg_break(cfg_break), .tx_enable(tx_enable), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .tx(tx), .busy(busy), .fifo_level(fifo_level),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int eff_bits();
    int n = int'(cfg_data_bits);
    if (n < 5 || n > DATA_W) n = DATA_W;
    return n;
  endfunction

  function automatic int eff_div();
    return (cfg_baud_div == 0) ? 1 : int'(cfg_baud_div);
  endfunction

  // Called at a negedge; returns at the following negedge.
  task automatic write_word(input logic [7:0] v, output bit accepted);
    frame_t f;
    wr_valid = 1'b1;
    wr_data  = v;
    accepted = wr_ready;
    if (accepted) begin
      f.value  = {8'h00, v};
      f.n      = eff_bits();
      f.par_en = cfg_parity_en;
      f.odd    = cfg_parity_odd;
      f.stop2  = cfg_stop2;
      f.div    = eff_div();
      exp_q.push_back(f);
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Waits for busy, then checks tx/busy on every cycle of the next expected
  // frame. Ends on the negedge of the frame's last cycle.
  task automatic check_frame(input int break_at, output int waited);
    frame_t f;
    bit bits[$];
    bit p;
    int total;
    @(negedge clk);
    waited = 0;
    while (!busy) begin
      if (waited >= 200) begin
        vectors++; miscompares++;
        $display("FAIL frame_start: busy never rose within %0d cycles", waited);
        return;
      end
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL frame_unexpected: busy=1 but no frame expected");
      return;
    end
    f = exp_q.pop_front();
    bits.push_back(1'b0);
    p = 1'b0;
    for (int i = 0; i < f.n; i++) begin
      bits.push_back(f.value[i]);
      p ^= f.value[i];
    end
    if (f.par_en) bits.push_back(p ^ f.odd);
    bits.push_back(1'b1);
    if (f.stop2) bits.push_back(1'b1);
    total = bits.size() * f.div;
    for (int k = 0; k < total; k++) begin
      if (k > 0) @(negedge clk);
      if (k == break_at) cfg_break = 1'b1;
      vectors++;
      if ({busy, tx} !== {1'b1, bits[k / f.div]}) begin
        miscompares++;
        $display("FAIL frame_bit: value=%h cycle %0d busy/tx got %b%b want 1%b",
                 f.value, k, busy, tx, bits[k / f.div]);
      end
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({tx, busy, wr_ready, fifo_empty, fifo_full} !== 5'b10110) begin
      miscompares++;
      $display("FAIL reset_flags: tx,busy,wr_ready,empty,full got %b want 10110",
               {tx, busy, wr_ready, fifo_empty, fifo_full});
    end
    vectors++;
    if (fifo_level !== '0) begin
      miscompares++;
      $display("FAIL reset_level: got %0d want 0", fifo_level);
    end
  endtask

  task automatic test_8n1();
    bit acc;
    int w;
    cfg_baud_div = 4; cfg_data_bits = 8; cfg_parity_en = 0; cfg_stop2 = 0;
    tx_enable = 1;
    write_word(8'h55, acc);
    vectors++;
    if ({fifo_empty, busy, tx} !== 3'b001) begin
      miscompares++;
      $display("FAIL latency_cycle1: empty,busy,tx got %b want 001", {fifo_empty, busy, tx});
    end
    check_frame(-1, w);
    vectors++;
    if (w !== 0) begin
      miscompares++;
      $display("FAIL latency_start: extra wait got %0d want 0", w);
    end
    @(negedge clk);
    vectors++;
    if ({busy, tx} !== 2'b01) begin
      miscompares++;
      $display("FAIL 8n1_end: busy,tx got %b want 01", {busy, tx});
    end
  endtask

  task automatic test_parity(input bit odd);
    bit acc;
    int w;
    cfg_baud_div = 2; cfg_data_bits = 7; cfg_parity_en = 1; cfg_parity_odd = odd;
    cfg_stop2 = 1; tx_enable = 1;
    write_word(8'h83, acc);
    check_frame(-1, w);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL parity_end: busy got %b want 0", busy);
    end
    cfg_parity_en = 0; cfg_stop2 = 0; cfg_data_bits = 8;
  endtask

  task automatic test_fifo_full();
    bit acc;
    int w;
    tx_enable = 0; cfg_baud_div = 2;
    for (int i = 0; i < 9; i++) begin
      write_word(8'(i * 37 + 5), acc);
      vectors++;
      if (acc !== (i < 8)) begin
        miscompares++;
        $display("FAIL fill_accept: write %0d accepted got %b want %b", i, acc, (i < 8));
      end
    end
    vectors++;
    if ({fifo_full, wr_ready, fifo_level} !== {1'b1, 1'b0, LW'(8)}) begin
      miscompares++;
      $display("FAIL fill_flags: full=%b ready=%b level=%0d want 1 0 8",
               fifo_full, wr_ready, fifo_level);
    end
    tx_enable = 1;
    for (int i = 0; i < 8; i++) begin
      check_frame(-1, w);
      vectors++;
      if (w !== 0) begin
        miscompares++;
        $display("FAIL back_to_back: frame %0d gap got %0d want 0", i, w);
      end
    end
    @(negedge clk);
    vectors++;
    if ({busy, fifo_level} !== {1'b0, LW'(0)}) begin
      miscompares++;
      $display("FAIL drain: busy=%b level=%0d want 0 0", busy, fifo_level);
    end
  endtask

  task automatic test_cfg_clamp();
    bit acc;
    int w;
    cfg_data_bits = 3; cfg_baud_div = 0; tx_enable = 1;
    write_word(8'hA7, acc);
    check_frame(-1, w);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL clamp_end: busy got %b want 0", busy);
    end
    cfg_data_bits = 8;
  endtask

  task automatic test_break();
    bit acc;
    int w;
    tx_enable = 0; cfg_baud_div = 4;
    write_word(8'h3C, acc);
    write_word(8'hC3, acc);
    tx_enable = 1;
    check_frame(10, w);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      vectors++;
      if ({tx, busy, fifo_level} !== {1'b0, 1'b0, LW'(1)}) begin
        miscompares++;
        $display("FAIL break_hold: cycle %0d tx=%b busy=%b level=%0d want 0 0 1",
                 i, tx, busy, fifo_level);
      end
    end
    cfg_break = 0;
    check_frame(-1, w);
    vectors++;
    if (w !== 0) begin
      miscompares++;
      $display("FAIL break_release: start delay got %0d want 0", w);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit acc;
    int w;
    tx_enable = 0; cfg_baud_div = 4;
    for (int i = 0; i < 4; i++) write_word(8'h00, acc);
    tx_enable = 1;
    w = 0;
    while (!busy && w < 50) begin
      @(negedge clk);
      w++;
    end
    repeat (6) @(negedge clk);
    vectors++;
    if ({tx, busy, fifo_level} !== {1'b0, 1'b1, LW'(3)}) begin
      miscompares++;
      $display("FAIL pre_reset: tx=%b busy=%b level=%0d want 0 1 3", tx, busy, fifo_level);
    end
    rst_n = 0;
    #1;
    vectors++;
    if ({tx, busy, fifo_level} !== {1'b1, 1'b0, LW'(0)}) begin
      miscompares++;
      $display("FAIL async_reset: tx=%b busy=%b level=%0d want 1 0 0", tx, busy, fifo_level);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if ({tx, busy, fifo_empty, fifo_level} !== {1'b1, 1'b0, 1'b1, LW'(0)}) begin
        miscompares++;
        $display("FAIL post_reset: cycle %0d tx=%b busy=%b empty=%b level=%0d want 1 0 1 0",
                 i, tx, busy, fifo_empty, fifo_level);
      end
    end
  endtask

  initial begin
    rst_n = 0;
    cfg_baud_div = 4; cfg_data_bits = 8; cfg_parity_en = 0; cfg_parity_odd = 0;
    cfg_stop2 = 0; cfg_break = 0; tx_enable = 0; wr_valid = 0; wr_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    test_reset();
    test_8n1();
    test_parity(1'b1);
    test_parity(1'b0);
    test_fifo_full();
    test_cfg_clamp();
    test_break();
    test_reset_mid();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: %0d expected frames never seen", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
